xor_serial_arbiter: RTL and testbench

- Shares one external single-bit XOR gate cell between two requesters, time-multiplexed.
- Each request is a WIDTH-bit operand pair. The block feeds it through the shared cell one bit per cycle, LSB first.
- It collects the result word and its parity, then returns them on a valid/ready response channel tagged with the requester id.
- It is the sequencing/arbitration layer above the gate-level XOR cell in the gates test designs.

---
 rtl/xor_serial_arbiter.sv | 145 ++++++++++++++
 tb/tb_xor_serial_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_serial_arbiter.sv
// Round-robin arbiter that time-shares one external single-bit XOR cell between two
// requesters, streaming each operand pair through it LSB first and returning word plus parity.
module xor_serial_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             xor_a,
    output logic             xor_b,
    input  logic             xor_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_parity,
    output logic             rsp_id,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             rr_r;
    logic             id_r;
    logic             parity_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [WIDTH-1:0] result_r;
    logic             grant_s;
    logic             accept_s;

    function automatic logic parity_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    // Next-state, grant selection, request handshake and shared-cell drive
    always_comb begin
        state_s    = state_r;
        grant_s    = 1'b0;
        accept_s   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        xor_a      = 1'b0;
        xor_b      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_s = rr_r;
                end else begin
                    grant_s = req1_valid;
                end
                if (req0_valid || req1_valid) begin
                    accept_s   = 1'b1;
                    req0_ready = ~grant_s;
                    req1_ready = grant_s;
                    state_s    = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                xor_a = op_a_r[cnt_r];
                xor_b = op_b_r[cnt_r];
                if (cnt_r == LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, operand capture, bit-serial result collection and priority pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            rr_r     <= 1'b0;
            id_r     <= 1'b0;
            parity_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            op_a_r   <= {WIDTH{1'b0}};
            op_b_r   <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_a_r   <= grant_s ? req1_a : req0_a;
                        op_b_r   <= grant_s ? req1_b : req0_b;
                        id_r     <= grant_s;
                        result_r <= {WIDTH{1'b0}};
                        parity_r <= 1'b0;
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    // The result bit comes from the external cell, never from an internal XOR
                    result_r[cnt_r] <= xor_y;
                    parity_r        <= parity_step(parity_r, xor_y);
                    cnt_r           <= (cnt_r == LAST) ? {CW{1'b0}} : cnt_r + CW'(1);
                end
                DONE: begin
                    if (rsp_ready) begin
                        rr_r <= ~id_r;
                    end
                end
                default: begin
                    rr_r <= rr_r;
                end
            endcase
        end
    end

    assign rsp_valid  = (state_r == DONE);
    assign rsp_y      = rsp_valid ? result_r : {WIDTH{1'b0}};
    assign rsp_parity = rsp_valid & parity_r;
    assign rsp_id     = rsp_valid & id_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_xor_serial_arbiter.sv
// Scoreboard bench for xor_serial_arbiter: WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_xor_serial_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic       xor_a, xor_b, xor_y;
    logic       rsp_valid, rsp_parity, rsp_id, busy;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_y;
    logic       force_one = 1'b0;

    logic       d1_v0 = 1'b0, d1_v1 = 1'b0, d1_r0, d1_r1;
    logic [0:0] d1_a0 = 1'b0, d1_b0 = 1'b0, d1_a1 = 1'b0, d1_b1 = 1'b0;
    logic       d1_xa, d1_xb, d1_xy, d1_rv, d1_rp, d1_rid, d1_busy;
    logic [0:0] d1_ry;

    assign xor_y = force_one ? 1'b1 : (xor_a ^ xor_b);
    assign d1_xy = d1_xa ^ d1_xb;

    always #5 clk = ~clk;

    xor_serial_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .xor_a(xor_a), .xor_b(xor_b), .xor_y(xor_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_parity(rsp_parity), .rsp_id(rsp_id), .busy(busy)
    );

    xor_serial_arbiter #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d1_v0), .req0_ready(d1_r0), .req0_a(d1_a0), .req0_b(d1_b0),
        .req1_valid(d1_v1), .req1_ready(d1_r1), .req1_a(d1_a1), .req1_b(d1_b1),
        .xor_a(d1_xa), .xor_b(d1_xb), .xor_y(d1_xy),
        .rsp_valid(d1_rv), .rsp_ready(1'b1), .rsp_y(d1_ry),
        .rsp_parity(d1_rp), .rsp_id(d1_rid), .busy(d1_busy)
    );

    typedef struct {
        logic [7:0] y;
        logic       p;
        logic       id;
    } exp_t;

    exp_t       sb[$];
    int         grants[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = -100;
    int         acc_count = 0;
    int         rsp_hs_cyc = -100;
    logic       run_active = 1'b0;
    logic [7:0] cur_a = 8'h00, cur_b = 8'h00;
    logic       model_rr = 1'b0;
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_par = 1'b0, prev_id = 1'b0;
    logic [7:0] prev_y = 8'h00;
    exp_t       e;
    logic       exp_g;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard push on accept, pop on response, cycle-level protocol checks
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (rsp_valid && !prev_valid) check_eq("latency", cyc, acc_cyc + 9);
            if (prev_valid && !prev_ready) begin
                check_eq("hold_valid", rsp_valid, 1'b1);
                check_eq("hold_y", rsp_y, prev_y);
                check_eq("hold_par", rsp_parity, prev_par);
                check_eq("hold_id", rsp_id, prev_id);
            end
            if (rsp_valid) check_eq("rdy_in_done", {req0_ready, req1_ready}, 2'b00);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_empty", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check_eq("rsp_y", rsp_y, e.y);
                    check_eq("rsp_par", rsp_parity, e.p);
                    check_eq("rsp_id", rsp_id, e.id);
                    model_rr = ~e.id;
                end
                rsp_hs_cyc = cyc;
            end
            if (run_active && cyc > acc_cyc && cyc <= acc_cyc + 8) begin
                check_eq("xor_a", xor_a, cur_a[cyc-acc_cyc-1]);
                check_eq("xor_b", xor_b, cur_b[cyc-acc_cyc-1]);
            end
            if (req0_ready || req1_ready) begin
                exp_g = (req0_valid && req1_valid) ? model_rr : req1_valid;
                check_eq("grant", req1_ready, exp_g);
                check_eq("one_rdy", req0_ready & req1_ready, 1'b0);
                cur_a = req1_ready ? req1_a : req0_a;
                cur_b = req1_ready ? req1_b : req0_b;
                e.y  = force_one ? 8'hFF : (cur_a ^ cur_b);
                e.p  = ^e.y;
                e.id = req1_ready;
                sb.push_back(e);
                grants.push_back(int'(req1_ready));
                acc_cyc = cyc;
                acc_count++;
                run_active = 1'b1;
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            prev_y     = rsp_y;
            prev_par   = rsp_parity;
            prev_id    = rsp_id;
        end
    end

    task automatic wait_accept(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (acc_count != n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic send(input int who, input logic [7:0] a, input logic [7:0] b);
        int n = acc_count;
        @(posedge clk);
        #1;
        if (who == 0) begin
            req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        wait_accept(n);
        @(posedge clk);
        #1;
        if (who == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("drain_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int n0;
        int gi;
        int t;
        bit seen;
        #1;
        check_eq("rst_outs", {req0_ready, req1_ready, xor_a, xor_b, rsp_valid, rsp_y,
                              rsp_parity, rsp_id, busy}, 16'h0000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request, basic result
        send(0, 8'hA5, 8'h3C);
        drain();

        // Simultaneous requests right after reset: strict alternation 0,1,0
        @(posedge clk); #1 rst_n = 1'b0;
        model_rr = 1'b0;
        #2 rst_n = 1'b1;
        req0_a = 8'hFF; req0_b = 8'h00; req1_a = 8'h01; req1_b = 8'h00;
        gi = grants.size();
        n0 = acc_count;
        @(posedge clk); #1 req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) wait_accept(n0 + i);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        check_eq("alt_count", grants.size() - gi, 3);
        if (grants.size() - gi == 3) begin
            check_eq("alt_g0", grants[gi], 0);
            check_eq("alt_g1", grants[gi+1], 1);
            check_eq("alt_g2", grants[gi+2], 0);
        end

        // Backpressure in DONE with requester 1 waiting
        rsp_ready = 1'b0;
        send(0, 8'h5A, 8'h0F);
        req1_a = 8'h33; req1_b = 8'h55; req1_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("bp_valid_seen", seen, 1'b1);
        repeat (5) @(negedge clk);
        n0 = acc_count;
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_accept(n0);
        check_eq("bp_accept_cyc", acc_cyc, rsp_hs_cyc + 1);
        @(posedge clk); #1 req1_valid = 1'b0;
        drain();

        // Reset during RUN cycle 3 aborts silently
        send(0, 8'hFF, 8'h00);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_outs", {req0_ready, req1_ready, xor_a, xor_b, rsp_valid, rsp_y,
                                rsp_parity, rsp_id, busy}, 16'h0000);
        sb.delete();
        run_active = 1'b0;
        model_rr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(1, 8'h0F, 8'hF0);
        drain();

        // Stuck-at-1 cell: result must reflect the cell output
        force_one = 1'b1;
        send(0, 8'h00, 8'h00);
        drain();
        force_one = 1'b0;

        // WIDTH=1 instance: one RUN cycle, response two cycles after the handshake cycle
        @(posedge clk); #1 d1_a0 = 1'b1; d1_b0 = 1'b1; d1_v0 = 1'b1;
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (d1_r0) begin
                t = cyc;
                break;
            end
        end
        check_eq("w1_accept", t >= 0, 1'b1);
        @(posedge clk); #1 d1_v0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (cyc == t + 1) check_eq("w1_drive", {d1_xa, d1_xb, d1_busy}, 3'b111);
            if (d1_rv) begin
                seen = 1'b1;
                check_eq("w1_lat", cyc, t + 2);
                check_eq("w1_y", d1_ry, 1'b0);
                check_eq("w1_par", d1_rp, 1'b0);
                check_eq("w1_id", d1_rid, 1'b0);
                break;
            end
        end
        check_eq("w1_seen", seen, 1'b1);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
